// File: rtl/seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_gen
// Purpose  : Burst frame generator. Each frame is the 7-bit pattern 1011001,
//            MSB first, sent as four 2-bit symbols: 10, 11, 00, {1, pad}.
//            A burst has cnt_in frames, and gap_in FILL cycles separate
//            consecutive frames. All outputs are registered. Each output
//            shows the state entered at the current clock edge.
// Ports    : clk       - clock, rising edge
//            rst       - synchronous active-high reset
//            start     - one-cycle burst request (cnt_in/gap_in/pad_in
//                        are sampled with it)
//            abort     - stops the burst at the next edge
//            cnt_in    - frames per burst (0 means the request is ignored)
//            gap_in    - FILL cycles between frames
//            pad_in    - LSB of the fourth symbol
//            data_out  - symbol stream
//            sym_valid - data_out carries a frame symbol
//            busy      - burst in progress
//            done      - one-cycle pulse when a burst completes normally
// Revision : 1.0 - initial release
// ============================================================================
module seq_gen #(
  parameter int          CNT_W = 4,
  parameter logic [1:0]  FILL  = 2'b00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic [1:0]       gap_in,
  input  logic             pad_in,
  output logic [1:0]       data_out,
  output logic             sym_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYM0 = 3'd1,
    SYM1 = 3'd2,
    SYM2 = 3'd3,
    SYM3 = 3'd4,
    GAP  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;    // frames still to send, including the current one
  logic [1:0]       gap_q,   gap_d;    // latched gap length
  logic [1:0]       gcnt_q,  gcnt_d;   // GAP cycles remaining
  logic             pad_q,   pad_d;
  logic [1:0]       data_q,  data_d;
  logic             valid_q, valid_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // Next-state logic and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    pad_d   = pad_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort && (cnt_in != '0)) begin
          state_d = SYM0;
          cnt_d   = cnt_in;
          gap_d   = gap_in;
          pad_d   = pad_in;
        end
      end
      SYM0: state_d = SYM1;
      SYM1: state_d = SYM2;
      SYM2: state_d = SYM3;
      SYM3: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (gap_q == 2'd0) begin
          state_d = SYM0;
        end else begin
          state_d = GAP;
          gcnt_d  = gap_q;
        end
      end
      GAP: begin
        gcnt_d = gcnt_q - 2'd1;
        if (gcnt_q == 2'd1) begin
          state_d = SYM0;
        end
      end
      default: begin
        // Illegal encoding: fall back to a clean IDLE
        state_d = IDLE;
        cnt_d   = '0;
        gcnt_d  = 2'd0;
      end
    endcase

    // Abort overrides every transition out of a non-IDLE state, including
    // the normal completion from SYM3, so it never produces a done pulse.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      gcnt_d  = 2'd0;
      done_d  = 1'b0;
    end

    // Outputs are decoded from the state being entered. That way the
    // registered outputs line up with state_q after the edge.
    data_d  = FILL;
    valid_d = 1'b0;
    case (state_d)
      SYM0: begin data_d = 2'b10;         valid_d = 1'b1; end
      SYM1: begin data_d = 2'b11;         valid_d = 1'b1; end
      SYM2: begin data_d = 2'b00;         valid_d = 1'b1; end
      SYM3: begin data_d = {1'b1, pad_d}; valid_d = 1'b1; end
      default: begin data_d = FILL;       valid_d = 1'b0; end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= 2'd0;
      gcnt_q  <= 2'd0;
      pad_q   <= 1'b0;
      data_q  <= FILL;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      pad_q   <= pad_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_out  = data_q;
  assign sym_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_gen
// Purpose  : Directed testbench for seq_gen. A table of per-cycle vectors
//            gives the inputs applied before an edge and the outputs expected
//            after that edge. Hand-written sequences cover abort, reset and
//            a gap-length run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst, start, abort, pad_in;
  logic [3:0] cnt_in;
  logic [1:0] gap_in;
  logic [1:0] data_out;
  logic       sym_valid, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  seq_gen #(.CNT_W(4), .FILL(2'b00)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .cnt_in   (cnt_in),
    .gap_in   (gap_in),
    .pad_in   (pad_in),
    .data_out (data_out),
    .sym_valid(sym_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, s, a;
    logic [3:0] c;
    logic [1:0] g;
    logic       p;
    logic [1:0] d;
    logic       v, b, dn;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, s, a, input logic [3:0] c, input logic [1:0] g,
                     input logic p, input logic [1:0] d, input logic v, b, dn);
    vec_t t;
    t.r = r; t.s = s; t.a = a; t.c = c; t.g = g; t.p = p;
    t.d = d; t.v = v; t.b = b; t.dn = dn;
    vecs.push_back(t);
  endtask

  // Idle-input vector with the given expected outputs
  task automatic exp(input logic [1:0] d, input logic v, b, dn);
    add(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, d, v, b, dn);
  endtask

  task automatic frame(input logic p);
    exp(2'b10, 1, 1, 0); exp(2'b11, 1, 1, 0); exp(2'b00, 1, 1, 0); exp({1'b1, p}, 1, 1, 0);
  endtask

  task automatic chk(input string name, input logic [1:0] d, input logic v, b, dn);
    n_tests++;
    if ({data_out, sym_valid, busy, done} !== {d, v, b, dn}) begin
      n_fail++;
      $display("FAIL %s: got data=%b valid=%b busy=%b done=%b, expected data=%b valid=%b busy=%b done=%b",
               name, data_out, sym_valid, busy, done, d, v, b, dn);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst = 0; start = 0; abort = 0; cnt_in = 0; gap_in = 0; pad_in = 0;
  endtask

  initial begin
    int busy_cnt, done_cnt, cyc;
    bit seen;

    rst = 1; start = 0; abort = 0; cnt_in = 0; gap_in = 0; pad_in = 0;

    // ---------------- table ----------------
    add(1, 0, 0, 4'd0, 2'd0, 0, 2'b00, 0, 0, 0);          // reset
    // cnt=1 gap=0 pad=1
    add(0, 1, 0, 4'd1, 2'd0, 1, 2'b10, 1, 1, 0);
    exp(2'b11, 1, 1, 0); exp(2'b00, 1, 1, 0); exp(2'b11, 1, 1, 0);
    exp(2'b00, 0, 0, 1); exp(2'b00, 0, 0, 0);
    // cnt=3 gap=2 pad=0, with start pulses while busy that must be ignored
    add(0, 1, 0, 4'd3, 2'd2, 0, 2'b10, 1, 1, 0);
    add(0, 1, 0, 4'd1, 2'd0, 1, 2'b11, 1, 1, 0);
    exp(2'b00, 1, 1, 0); exp(2'b10, 1, 1, 0);
    exp(2'b00, 0, 1, 0);
    add(0, 1, 0, 4'd1, 2'd0, 1, 2'b00, 0, 1, 0);
    frame(0);
    exp(2'b00, 0, 1, 0); exp(2'b00, 0, 1, 0);
    frame(0);
    exp(2'b00, 0, 0, 1); exp(2'b00, 0, 0, 0);
    // cnt=2 gap=0: back-to-back frames
    add(0, 1, 0, 4'd2, 2'd0, 0, 2'b10, 1, 1, 0);
    exp(2'b11, 1, 1, 0); exp(2'b00, 1, 1, 0); exp(2'b10, 1, 1, 0);
    frame(0);
    exp(2'b00, 0, 0, 1);
    // cnt=0 start, start+abort in IDLE: ignored
    add(0, 1, 0, 4'd0, 2'd2, 1, 2'b00, 0, 0, 0);
    add(0, 1, 1, 4'd3, 2'd0, 1, 2'b00, 0, 0, 0);
    exp(2'b00, 0, 0, 0);
    // start accepted in the done cycle
    add(0, 1, 0, 4'd1, 2'd0, 0, 2'b10, 1, 1, 0);
    exp(2'b11, 1, 1, 0); exp(2'b00, 1, 1, 0); exp(2'b10, 1, 1, 0);
    exp(2'b00, 0, 0, 1);
    add(0, 1, 0, 4'd1, 2'd1, 1, 2'b10, 1, 1, 0);
    exp(2'b11, 1, 1, 0); exp(2'b00, 1, 1, 0); exp(2'b11, 1, 1, 0);
    exp(2'b00, 0, 0, 1); exp(2'b00, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].r; start = vecs[i].s; abort = vecs[i].a;
      cnt_in = vecs[i].c; gap_in = vecs[i].g; pad_in = vecs[i].p;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].d, vecs[i].v, vecs[i].b, vecs[i].dn);
    end

    // ---------------- abort during SYM2 of frame 1, cnt=4 ----------------
    idle_in(); start = 1; cnt_in = 4'd4; gap_in = 2'd1;
    tick(); idle_in();
    chk("abort_sym0", 2'b10, 1, 1, 0);
    tick();
    tick();
    chk("abort_sym2", 2'b00, 1, 1, 0);
    abort = 1;
    tick(); idle_in();
    chk("abort_next", 2'b00, 0, 0, 0);
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    chk_int("abort_no_done", done_cnt, 0);
    chk_int("abort_no_busy", busy_cnt, 0);

    // ---------------- reset in SYM1 ----------------
    start = 1; cnt_in = 4'd4; gap_in = 2'd0;
    tick(); idle_in();
    tick();
    chk("rst_sym1", 2'b11, 1, 1, 0);
    rst = 1;
    tick(); idle_in();
    chk("rst_next", 2'b00, 0, 0, 0);
    done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    chk_int("rst_quiet", done_cnt, 0);

    // ---------------- cnt=2 gap=3, bounded wait for done ----------------
    start = 1; cnt_in = 4'd2; gap_in = 2'd3; pad_in = 1;
    busy_cnt = 0; seen = 0; cyc = 0;
    tick(); idle_in();
    while (!seen && cyc < 50) begin
      if (busy) busy_cnt++;
      if (done) seen = 1;
      else tick();
      cyc++;
    end
    chk_int("gap3_done_seen", int'(seen), 1);
    chk_int("gap3_busy_len", busy_cnt, 11);
    chk("gap3_done_cycle", 2'b00, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
